// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared memory port between the I-cache and the D-cache, one line at a time.
// Define ARB_ROUND_ROBIN_EN for alternating grants on ties (default: D over I).
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t state;
  logic   d_req;
  logic   d_wins;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;  // 1: D was served last, 0: I (reset value)
  assign d_wins = d_req && (!i_read || !last_grant_d);
`else
  assign d_wins = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide line registers are reset too, because the returned
      // data buses must read as zero straight out of reset.
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_resp    <= 1'b0;
      d_resp    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d <= 1'b0;
`endif
    end else begin
      // NOTE: every register here uses <= so all of them see the pre-edge
      // values of each other, like the flops they become.
      case (state)
        IDLE: begin
          if (d_wins) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_write <= d_write;   // read+write together counts as a write
            mem_read  <= ~d_write;
            state     <= BUSY_D;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b1;
`endif
          end else if (i_read) begin
            mem_addr <= i_addr;
            mem_read <= 1'b1;
            state    <= BUSY_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b0;
`endif
          end
        end
        BUSY_I: begin
          if (mem_resp) begin
            mem_read <= 1'b0;
            i_rdata  <= mem_rdata;
            i_resp   <= 1'b1;
            state    <= RESP;
          end
        end
        BUSY_D: begin
          if (mem_resp) begin
            if (mem_read) begin
              d_rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_resp    <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a transaction-level model is compared
// every cycle, and directed scenarios add hand-computed literal expectations.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // ---------------- memory responder ----------------
  int          mem_lat  = 3;
  logic [LW-1:0] mem_data = '0;
  int          stray_req = 0;
  int          stray_ack = 0;
  int          lat_cnt   = 0;

  always @(posedge clk) begin
    #1;
    if (stray_req != stray_ack) begin
      mem_resp  = 1'b1;
      mem_rdata = mem_data;
      stray_ack = stray_req;
    end else if (mem_resp) begin
      mem_resp = 1'b0;
    end else if (mem_read | mem_write) begin
      lat_cnt++;
      if (lat_cnt >= mem_lat) begin
        mem_resp  = 1'b1;
        mem_rdata = mem_data;
        lat_cnt   = 0;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // ---------------- transaction-level model ----------------
  // A transaction is open from its grant until memory answers; the requester gets
  // its pulse the cycle after, and that pulse cycle never carries a new grant.
  logic          model_ok = 1'b0;
  logic          t_open, t_is_d, t_wr, last_d, was_resp, take_d;
  logic          exp_i_resp, exp_d_resp, exp_mem_read, exp_mem_write;
  logic [AW-1:0] exp_mem_addr;
  logic [LW-1:0] exp_mem_wdata, exp_i_rdata, exp_d_rdata;

  always @(posedge clk) begin
    if (rst) begin
      t_open = 0; t_is_d = 0; t_wr = 0; last_d = 0;
      exp_i_resp = 0; exp_d_resp = 0;
      exp_mem_addr = '0; exp_mem_wdata = '0; exp_i_rdata = '0; exp_d_rdata = '0;
      model_ok = 1'b1;
    end else begin
      was_resp   = exp_i_resp | exp_d_resp;
      exp_i_resp = 0;
      exp_d_resp = 0;
      if (t_open) begin
        if (mem_resp) begin
          t_open = 0;
          if (t_is_d) begin
            exp_d_resp = 1;
            if (!t_wr) exp_d_rdata = mem_rdata;
          end else begin
            exp_i_resp  = 1;
            exp_i_rdata = mem_rdata;
          end
        end
      end else if (!was_resp) begin
        take_d = (d_read | d_write) && (!i_read || !RR || !last_d);
        if (take_d) begin
          t_open = 1; t_is_d = 1; t_wr = d_write; last_d = 1;
          exp_mem_addr = d_addr; exp_mem_wdata = d_wdata;
        end else if (i_read) begin
          t_open = 1; t_is_d = 0; t_wr = 0; last_d = 0;
          exp_mem_addr = i_addr;
        end
      end
    end
    exp_mem_read  = t_open && !t_wr;
    exp_mem_write = t_open && t_wr;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("mem_read",  mem_read,  exp_mem_read);
      check("mem_write", mem_write, exp_mem_write);
      check("mem_addr",  mem_addr,  exp_mem_addr);
      check("mem_wdata", mem_wdata, exp_mem_wdata);
      check("i_resp",    i_resp,    exp_i_resp);
      check("d_resp",    d_resp,    exp_d_resp);
      check("i_rdata",   i_rdata,   exp_i_rdata);
      check("d_rdata",   d_rdata,   exp_d_rdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_resp(input bit want_d, inout int cycles);
    logic seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step(1);
      cycles++;
      seen = want_d ? d_resp : i_resp;
    end
    check(want_d ? "d_resp_seen" : "i_resp_seen", seen, 1'b1);
  endtask

  localparam logic [LW-1:0] DATA_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] DATA_D  = {8{32'hD00DF00D}};
  localparam logic [LW-1:0] DATA_I  = {8{32'h11111111}};
  localparam logic [LW-1:0] WDATA   = {8{32'h12345678}};

  initial begin
    int    cyc;
    bit    order[$];
    bit    exp_order[4];
    logic [LW-1:0] ff_data;

    // reset state
    step(2);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_i_rdata",  i_rdata,  '0);
    check("rst_d_resp",   d_resp,   1'b0);
    rst = 1'b0;
    step(1);

    // 1: single I-cache read
    mem_lat = 3; mem_data = DATA_A5;
    i_read = 1'b1; i_addr = 32'h60;
    step(1);
    cyc = 1;
    check("t1_mem_read", mem_read, 1'b1);
    check("t1_mem_addr", mem_addr, 32'h60);
    wait_resp(1'b0, cyc);
    i_read = 1'b0;
    check("t1_latency", cyc, 4);  // grant edge, then 3 memory cycles
    check("t1_i_rdata", i_rdata, DATA_A5);
    check("t1_d_resp",  d_resp,  1'b0);
    step(2);

    // 2: simultaneous I and D reads, D first
    mem_data = DATA_D;
    i_read = 1'b1; i_addr = 32'h80;
    d_read = 1'b1; d_addr = 32'h100;
    step(1);
    check("t2_first_addr", mem_addr, 32'h100);
    cyc = 0;
    wait_resp(1'b1, cyc);
    d_read = 1'b0;
    mem_data = DATA_I;
    check("t2_d_rdata", d_rdata, DATA_D);
    step(2);
    check("t2_second_addr", mem_addr, 32'h80);
    check("t2_second_read", mem_read, 1'b1);
    wait_resp(1'b0, cyc);
    i_read = 1'b0;
    check("t2_i_rdata", i_rdata, DATA_I);
    step(2);

    // 3: D-cache writeback; requester-side changes ignored while busy
    mem_data = {LW{1'b1}};
    d_write = 1'b1; d_addr = 32'h200; d_wdata = WDATA;
    step(1);
    check("t3_mem_write", mem_write, 1'b1);
    check("t3_mem_read",  mem_read,  1'b0);
    d_wdata = ~WDATA; d_addr = 32'h999;
    step(1);
    check("t3_wdata_stable", mem_wdata, WDATA);
    check("t3_addr_stable",  mem_addr,  32'h200);
    cyc = 0;
    wait_resp(1'b1, cyc);
    d_write = 1'b0;
    check("t3_d_rdata_kept", d_rdata, DATA_D);
    check("t3_i_rdata_kept", i_rdata, DATA_I);
    step(2);

    // 4: both requesting continuously, fresh reset for the arbitration history
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    mem_lat = 2; mem_data = DATA_I;
    i_read = 1'b1; i_addr = 32'h400;
    d_read = 1'b1; d_addr = 32'h500;
    for (int k = 0; k < 200 && order.size() < 4; k++) begin
      step(1);
      if (d_resp) order.push_back(1'b1);
      if (i_resp) order.push_back(1'b0);
    end
    i_read = 1'b0; d_read = 1'b0;
    if (RR) exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
    else    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
    check("t4_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      check($sformatf("t4_grant%0d_is_d", k), order[k], exp_order[k]);
    step(3);

    // 5: reset during BUSY_D aborts, later stale mem_resp ignored
    mem_lat = 10; mem_data = DATA_A5;
    d_read = 1'b1; d_addr = 32'h300;
    step(3);
    check("t5_busy", mem_read, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0; d_read = 1'b0;
    check("t5_mem_read",  mem_read,  1'b0);
    check("t5_mem_write", mem_write, 1'b0);
    check("t5_d_resp",    d_resp,    1'b0);
    stray_req++;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("t5_no_d_resp", d_resp, 1'b0);
    end
    check("t5_d_rdata", d_rdata, '0);

    // 6: mem_resp pulse while idle with no requests
    ff_data  = {LW{1'b1}};
    mem_data = ff_data;
    stray_req++;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("t6_no_i_resp", i_resp, 1'b0);
      check("t6_no_d_resp", d_resp, 1'b0);
    end
    check("t6_i_rdata", i_rdata, '0);
    check("t6_d_rdata", d_rdata, '0);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
